// File: rtl/branch_stall_ctrl_if.sv
// branch_stall_ctrl_if
//  Groups the signals between the ID-stage branch controller and the rest of
//  the pipeline: the IF/ID instruction fields, the flag register, and the
//  hazard unit on one side, and the stall, redirect and flush controls on the
//  other.
//  master : pipeline side. Drives the instruction, flag and hazard inputs and
//           receives the stall and redirect controls.
//  slave  : branch_stall_ctrl side.
//  Signals:
//   if_id_valid, opcode[3:0], ccc[2:0]  IF/ID instruction fields
//   flags[2:0] {Z,V,N}                  committed flag register
//   flag_wr_pend, br_hazard, halt       hazard and halt status
//   stall_en, take_branch, flush        pipeline controls
//   has_stalled, stall_cnt[CNT_W-1:0]   status and statistics
interface branch_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             if_id_valid;
  logic [3:0]       opcode;
  logic [2:0]       ccc;
  logic [2:0]       flags;
  logic             flag_wr_pend;
  logic             br_hazard;
  logic             halt;
  logic             stall_en;
  logic             take_branch;
  logic             flush;
  logic             has_stalled;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output if_id_valid, opcode, ccc, flags, flag_wr_pend, br_hazard, halt,
    input  stall_en, take_branch, flush, has_stalled, stall_cnt
  );

  modport slave (
    input  if_id_valid, opcode, ccc, flags, flag_wr_pend, br_hazard, halt,
    output stall_en, take_branch, flush, has_stalled, stall_cnt
  );
endinterface

// File: rtl/branch_stall_ctrl.sv
// branch_stall_ctrl
//  Resolves conditional branches in the ID stage of the 5-stage WISC
//  pipeline. The controller freezes the PC and IF/ID while the flags or the
//  BR target register are not yet valid. It then evaluates the branch
//  condition against the flag register and requests a redirect together with
//  a flush of the instruction being fetched.
//  Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    branch_stall_ctrl_if.slave (instruction, flags, hazards in;
//          stall_en, take_branch, flush, has_stalled, stall_cnt out)
module branch_stall_ctrl #(
  parameter int       FLAG_WAIT = 1,
  parameter logic [3:0] OP_B    = 4'hC,
  parameter logic [3:0] OP_BR   = 4'hD,
  parameter int       CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_stall_ctrl_if.slave bus
);

  localparam int WAIT_W = (FLAG_WAIT > 1) ? $clog2(FLAG_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(FLAG_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REG_WAIT,
    FLAG_WAIT_ST,
    RESOLVE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic [WAIT_W-1:0] wait_dec;
  logic [2:0]        ccc_q;
  logic              is_br_q;
  logic              latch_en;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              stall_int;
  logic              take_int;
  logic              is_branch;
  logic              is_br_op;

  // Condition decode on {Z,V,N}. GE reduces to Z | ~N and LE to N | Z.
  function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
    logic z;
    logic v;
    logic n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'b000:  cond_met = ~z;
      3'b001:  cond_met = z;
      3'b010:  cond_met = ~z & ~n;
      3'b011:  cond_met = n;
      3'b100:  cond_met = z | (~z & ~n);
      3'b101:  cond_met = n | z;
      3'b110:  cond_met = v;
      default: cond_met = 1'b1;
    endcase
  endfunction

  assign is_br_op  = (bus.opcode == OP_BR);
  assign is_branch = bus.if_id_valid & ((bus.opcode == OP_B) | is_br_op) & ~bus.halt;

  // Saturating decrement of the flag-wait counter.
  assign wait_dec = (wait_cnt == '0) ? '0 : wait_cnt - 1'b1;

  // The wait counter holds the number of stall cycles still required after the
  // current one. A stall cycle that leaves the counter at zero with no flag
  // write pending is therefore the last one, and the branch resolves on the
  // next cycle. As a result, exactly FLAG_WAIT stall cycles occur when nothing
  // else holds the branch.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    latch_en   = 1'b0;
    stall_int  = 1'b0;
    take_int   = 1'b0;
    if (bus.halt) begin
      state_next = IDLE;
      wait_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_branch) begin
            latch_en = 1'b1;
            if (is_br_op && bus.br_hazard) begin
              stall_int  = 1'b1;
              state_next = REG_WAIT;
            end else if (bus.ccc == 3'b111) begin
              take_int = 1'b1;
            end else begin
              stall_int = 1'b1;
              wait_next = WAIT_LOAD;
              if (WAIT_LOAD == '0 && !bus.flag_wr_pend) begin
                state_next = RESOLVE;
              end else begin
                state_next = FLAG_WAIT_ST;
              end
            end
          end
        end
        REG_WAIT: begin
          stall_int = 1'b1;
          if (!(is_br_q && bus.br_hazard)) begin
            if (ccc_q == 3'b111) begin
              state_next = RESOLVE;
            end else begin
              wait_next = WAIT_LOAD;
              if (WAIT_LOAD == '0 && !bus.flag_wr_pend) begin
                state_next = RESOLVE;
              end else begin
                state_next = FLAG_WAIT_ST;
              end
            end
          end
        end
        FLAG_WAIT_ST: begin
          stall_int = 1'b1;
          wait_next = wait_dec;
          if (wait_dec == '0 && !bus.flag_wr_pend) begin
            state_next = RESOLVE;
          end
        end
        RESOLVE: begin
          take_int   = cond_met(ccc_q, bus.flags);
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State, wait counter and latched branch fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ccc_q    <= '0;
      is_br_q  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (latch_en) begin
        ccc_q   <= bus.ccc;
        is_br_q <= is_br_op;
      end
    end
  end

  // Count stall cycles and saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_int && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // Gating the outputs with rst_n makes stall_en drop as soon as reset is
  // asserted, even while a branch is still present in IF/ID.
  assign bus.stall_en    = rst_n & stall_int;
  assign bus.take_branch = rst_n & take_int;
  assign bus.flush       = rst_n & take_int;
  assign bus.has_stalled = rst_n & (state == RESOLVE) & ~bus.halt;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_branch_stall_ctrl.sv
// tb_branch_stall_ctrl
//  Table-driven, cycle-by-cycle bench for branch_stall_ctrl (FLAG_WAIT=1).
//  Each table row holds one cycle of inputs and the outputs expected in that
//  cycle. Hand-written sequences cover reset during a stall and saturation of
//  the stall counter.
module tb_branch_stall_ctrl;

  localparam int CNT_W = 16;

  typedef struct {
    logic       valid;
    logic [3:0] op;
    logic [2:0] ccc;
    logic [2:0] flags;
    logic       pend;
    logic       haz;
    logic       halt;
    logic       exp_stall;
    logic       exp_take;
    logic       exp_has;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  vec_t vecs[$];

  branch_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_stall_ctrl #(
    .FLAG_WAIT(1),
    .OP_B(4'hC),
    .OP_BR(4'hD),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic valid, input logic [3:0] op, input logic [2:0] ccc,
                     input logic [2:0] flags, input logic pend, input logic haz,
                     input logic halt, input logic exp_stall, input logic exp_take,
                     input logic exp_has, input logic [15:0] exp_cnt);
    vec_t v;
    v.valid = valid; v.op = op; v.ccc = ccc; v.flags = flags;
    v.pend = pend; v.haz = haz; v.halt = halt;
    v.exp_stall = exp_stall; v.exp_take = exp_take;
    v.exp_has = exp_has; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input logic valid, input logic [3:0] op, input logic [2:0] ccc,
                                input logic [2:0] flags, input logic pend, input logic haz,
                                input logic halt);
    bus.if_id_valid  = valid;
    bus.opcode       = op;
    bus.ccc          = ccc;
    bus.flags        = flags;
    bus.flag_wr_pend = pend;
    bus.br_hazard    = haz;
    bus.halt         = halt;
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 4'h0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input logic stall, input logic take,
                           input logic has, input logic [15:0] cnt);
    check_output({tag, " stall_en"}, 32'(bus.stall_en), 32'(stall));
    check_output({tag, " take_branch"}, 32'(bus.take_branch), 32'(take));
    check_output({tag, " flush"}, 32'(bus.flush), 32'(take));
    check_output({tag, " has_stalled"}, 32'(bus.has_stalled), 32'(has));
    check_output({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(cnt));
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Columns: valid op ccc flags pend haz halt | stall take has cnt
    // B EQ with Z=1: one stall, then taken
    add(1, 4'hC, 3'b001, 3'b100, 0, 0, 0,  1, 0, 0, 16'd0);
    add(1, 4'hC, 3'b001, 3'b100, 0, 0, 0,  0, 1, 1, 16'd1);
    add(0, 4'h0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd1);
    // B GT with N=1: one stall, then not taken
    add(1, 4'hC, 3'b010, 3'b001, 0, 0, 0,  1, 0, 0, 16'd1);
    add(1, 4'hC, 3'b010, 3'b001, 0, 0, 0,  0, 0, 1, 16'd2);
    // Non-branch instruction
    add(1, 4'h1, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd2);
    // B always: taken in the same cycle, no stall
    add(1, 4'hC, 3'b111, 3'b000, 0, 0, 0,  0, 1, 0, 16'd2);
    add(0, 4'h0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd2);
    // BR NE with hazard for two cycles; live ccc changes but latched NE decides
    add(1, 4'hD, 3'b000, 3'b000, 0, 1, 0,  1, 0, 0, 16'd2);
    add(1, 4'hD, 3'b000, 3'b000, 0, 1, 0,  1, 0, 0, 16'd3);
    add(1, 4'hD, 3'b001, 3'b000, 0, 0, 0,  1, 0, 0, 16'd4);
    add(1, 4'hD, 3'b001, 3'b000, 0, 0, 0,  0, 1, 1, 16'd5);
    add(0, 4'h0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd5);
    // B OV, flag writer pending for the first two stall cycles, then V=1
    add(1, 4'hC, 3'b110, 3'b000, 1, 0, 0,  1, 0, 0, 16'd5);
    add(1, 4'hC, 3'b110, 3'b000, 1, 0, 0,  1, 0, 0, 16'd6);
    add(1, 4'hC, 3'b110, 3'b010, 0, 0, 0,  1, 0, 0, 16'd7);
    add(1, 4'hC, 3'b110, 3'b010, 0, 0, 0,  0, 1, 1, 16'd8);
    add(0, 4'h0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd8);
    // B GE with N=1, Z=0: not taken
    add(1, 4'hC, 3'b100, 3'b001, 0, 0, 0,  1, 0, 0, 16'd8);
    add(1, 4'hC, 3'b100, 3'b001, 0, 0, 0,  0, 0, 1, 16'd9);
    // B LE with Z=1: taken
    add(1, 4'hC, 3'b101, 3'b100, 0, 0, 0,  1, 0, 0, 16'd9);
    add(1, 4'hC, 3'b101, 3'b100, 0, 0, 0,  0, 1, 1, 16'd10);
    add(0, 4'h0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd10);
    // Halt masks a branch in IDLE and in RESOLVE
    add(1, 4'hC, 3'b001, 3'b000, 0, 0, 1,  0, 0, 0, 16'd10);
    add(1, 4'hC, 3'b000, 3'b000, 0, 0, 0,  1, 0, 0, 16'd10);
    add(1, 4'hC, 3'b000, 3'b000, 0, 0, 1,  0, 0, 0, 16'd11);
    add(0, 4'h0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd11);
    // BR LT with hazard and flag pending together; hazard handled first
    add(1, 4'hD, 3'b011, 3'b001, 1, 1, 0,  1, 0, 0, 16'd11);
    add(1, 4'hD, 3'b011, 3'b001, 1, 1, 0,  1, 0, 0, 16'd12);
    add(1, 4'hD, 3'b011, 3'b001, 1, 0, 0,  1, 0, 0, 16'd13);
    add(1, 4'hD, 3'b011, 3'b001, 0, 0, 0,  1, 0, 0, 16'd14);
    add(1, 4'hD, 3'b011, 3'b001, 0, 0, 0,  0, 1, 1, 16'd15);
    add(0, 4'h0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd15);
    // BR always without hazard: taken at once
    add(1, 4'hD, 3'b111, 3'b000, 0, 0, 0,  0, 1, 0, 16'd15);
    add(0, 4'h0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd15);
    // BR always with hazard: waits for the register, then resolves
    add(1, 4'hD, 3'b111, 3'b000, 0, 1, 0,  1, 0, 0, 16'd15);
    add(1, 4'hD, 3'b111, 3'b000, 0, 0, 0,  1, 0, 0, 16'd16);
    add(1, 4'hD, 3'b111, 3'b000, 0, 0, 0,  0, 1, 1, 16'd17);
    add(0, 4'h0, 3'b000, 3'b000, 0, 0, 0,  0, 0, 0, 16'd17);

    // Reset state, even with a branch present at the inputs
    rst_n = 1'b0;
    apply_stimulus(1'b1, 4'hC, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    apply_idle();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i].valid, vecs[i].op, vecs[i].ccc, vecs[i].flags,
                     vecs[i].pend, vecs[i].haz, vecs[i].halt);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_take,
                vecs[i].exp_has, vecs[i].exp_cnt);
    end

    // Reset asserted while in FLAG_WAIT
    @(negedge clk);
    apply_stimulus(1'b1, 4'hC, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    #1;
    check_output("rstmid enter stall", 32'(bus.stall_en), 32'd1);
    @(negedge clk);
    #1;
    check_output("rstmid wait stall", 32'(bus.stall_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("rstmid stall_en", 32'(bus.stall_en), 32'd0);
    check_output("rstmid stall_cnt", 32'(bus.stall_cnt), 32'd0);
    apply_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b1, 4'hC, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    check_output("rstmid idle take", 32'(bus.take_branch), 32'd1);
    check_output("rstmid idle stall", 32'(bus.stall_en), 32'd0);

    // Stall for 2^CNT_W+5 cycles; the counter must saturate rather than wrap
    @(negedge clk);
    apply_stimulus(1'b1, 4'hC, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    repeat ((1 << CNT_W) + 5) @(posedge clk);
    @(negedge clk);
    #1;
    check_output("sat stall_cnt", 32'(bus.stall_cnt), 32'h0000FFFF);
    check_output("sat stall_en", 32'(bus.stall_en), 32'd1);
    apply_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
